// File: rtl/oclib_pkg.sv
// Shared CSR tree request/response structs for the oclib interconnect.
package oclib_pkg;

   localparam int CsrAddrW = 32;
   localparam int CsrDataW = 32;

   typedef struct packed {
      logic [CsrAddrW-1:0] address;
      logic [CsrDataW-1:0] wdata;
      logic                read;
      logic                write;
   } csr_32_tree_s;

   typedef struct packed {
      logic [CsrDataW-1:0] rdata;
      logic                ready;
      logic                error;
   } csr_32_tree_fb_s;

endpackage

// File: rtl/oclib_arb_rr.sv
// Combinational round-robin arbiter: search starts one past the last winner.
module oclib_arb_rr #(
   parameter int Requesters = 2,
   parameter int IdxW       = (Requesters > 1) ? $clog2(Requesters) : 1
) (
   input  logic [Requesters-1:0] req,
   input  logic [IdxW-1:0]       last,
   output logic [IdxW-1:0]       winner,
   output logic                  valid
);

   if (Requesters == 1) begin : g_single
      assign winner = '0;
      assign valid  = req[0];
   end else begin : g_rr
      logic [IdxW-1:0] idx;

      always_comb begin
         winner = '0;
         valid  = 1'b0;
         idx    = '0;
         for (int k = 1; k <= Requesters; k++) begin
            idx = IdxW'((int'(last) + k) % Requesters);
            if (!valid && req[idx]) begin
               valid  = 1'b1;
               winner = idx;
            end
         end
      end
   end

endmodule

// File: rtl/oclib_csr_tree_arbiter.sv
// Shares one CSR tree port among several masters, one transaction at a time,
// with round-robin grant and a timeout guard against dead targets.
module oclib_csr_tree_arbiter
   import oclib_pkg::*;
#(
   parameter type CsrType        = csr_32_tree_s,
   parameter type CsrFbType      = csr_32_tree_fb_s,
   parameter int  Inputs         = 2,
   parameter int  TimeoutCycles  = 1024,
   parameter int  ErrorCountBits = 8
) (
   input  logic                                          clock,
   input  logic                                          reset,
   input  CsrType                                        in [0:Inputs-1],
   output CsrFbType                                      inFb [0:Inputs-1],
   output CsrType                                        out,
   input  CsrFbType                                      outFb,
   output logic [((Inputs > 1) ? $clog2(Inputs) : 1)-1:0] grant,
   output logic                                          busy,
   output logic [ErrorCountBits-1:0]                     timeoutCount
);

   localparam int GrantW    = (Inputs > 1) ? $clog2(Inputs) : 1;
   localparam int TimerW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam bit TimeoutEn = (TimeoutCycles != 0);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StRelease
   } state_e;

   state_e                    state_q, state_d;
   CsrType                    out_q, out_d, win_req;
   CsrFbType                  fb_q, fb_d;
   logic [GrantW-1:0]         grant_q, grant_d;
   logic [GrantW-1:0]         last_q, last_d;
   logic [GrantW-1:0]         arb_winner;
   logic [TimerW-1:0]         timer_q, timer_d;
   logic [ErrorCountBits-1:0] tcount_q, tcount_d;
   logic [Inputs-1:0]         req_vec;
   logic                      arb_valid;
   logic                      owner_req;

   for (genvar i = 0; i < Inputs; i++) begin : g_req
      assign req_vec[i] = in[i].read | in[i].write;
   end

   oclib_arb_rr #(
      .Requesters (Inputs),
      .IdxW       (GrantW)
   ) u_arb (
      .req    (req_vec),
      .last   (last_q),
      .winner (arb_winner),
      .valid  (arb_valid)
   );

   always_comb begin
      win_req = '0;
      for (int i = 0; i < Inputs; i++) begin
         if (GrantW'(i) == arb_winner) win_req = in[i];
      end
   end

   always_comb begin
      owner_req = 1'b0;
      for (int i = 0; i < Inputs; i++) begin
         if (GrantW'(i) == grant_q) owner_req = req_vec[i];
      end
   end

   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      fb_d     = '0;
      grant_d  = grant_q;
      last_d   = last_q;
      timer_d  = timer_q;
      tcount_d = tcount_q;
      unique case (state_q)
         StIdle: begin
            if (arb_valid) begin
               out_d   = win_req;
               grant_d = arb_winner;
               timer_d = '0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (TimeoutEn) timer_d = timer_q + TimerW'(1);
            if (outFb.ready) begin
               fb_d.ready  = 1'b1;
               fb_d.error  = outFb.error;
               fb_d.rdata  = out_q.write ? '0 : outFb.rdata;
               out_d.read  = 1'b0;
               out_d.write = 1'b0;
               state_d     = StRelease;
            end else if (TimeoutEn && timer_q == TimerW'(TimeoutCycles)) begin
               // timer holds completed wait cycles, so the error lands T+1 after out
               fb_d.ready  = 1'b1;
               fb_d.error  = 1'b1;
               out_d.read  = 1'b0;
               out_d.write = 1'b0;
               if (tcount_q != '1) tcount_d = tcount_q + ErrorCountBits'(1);
               state_d     = StRelease;
            end
         end
         StRelease: begin
            if (!owner_req) begin
               last_d  = grant_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         out_q    <= '0;
         fb_q     <= '0;
         grant_q  <= '0;
         last_q   <= GrantW'(Inputs - 1);
         timer_q  <= '0;
         tcount_q <= '0;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         fb_q     <= fb_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         timer_q  <= timer_d;
         tcount_q <= tcount_d;
      end
   end

   always_comb begin
      for (int i = 0; i < Inputs; i++) begin
         inFb[i] = (GrantW'(i) == grant_q) ? fb_q : '0;
      end
   end

   assign out          = out_q;
   assign grant        = grant_q;
   assign busy         = (state_q != StIdle);
   assign timeoutCount = tcount_q;

endmodule
